// File: rtl/axi_pkg.sv
// Shared AXI write-slave types: burst/response codes, FSM encoding, AW control payload.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Latched address-channel control fields (address kept separately, it is parametric)
  typedef struct packed {
    logic       id;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
  } aw_ctrl_t;

  // True when a beat of 2^size bytes fits in a data bus of strb_w bytes
  function automatic logic size_ok(input logic [2:0] size, input int unsigned strb_w);
    return (32'(1) << size) <= strb_w;
  endfunction

endpackage

// File: rtl/axi_waddr_gen.sv
// Next beat address: FIXED holds, INCR advances by 2^size with natural wrap, others hold.
module axi_waddr_gen
  import axi_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        size,
  input  logic [1:0]        burst,
  output logic [ADDR_W-1:0] next_addr_c
);

  // Address step selection
  always_comb begin
    next_addr_c = addr;
    if (burst == BURST_INCR) begin
      next_addr_c = addr + (ADDR_W'(1) << size);
    end
  end

endmodule

// File: rtl/axi_write.sv
// AXI write slave front end: one burst at a time, beats forwarded to a simple core write port.
module axi_write
  import axi_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  AWID,
  input  logic [ADDR_W-1:0]     AWADDR,
  input  logic [7:0]            AWLEN,
  input  logic [2:0]            AWSIZE,
  input  logic [1:0]            AWBURST,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [DATA_W-1:0]     WDATA,
  input  logic [DATA_W/8-1:0]   WSTRB,
  input  logic                  WLAST,
  input  logic                  WVALID,
  output logic                  WREADY,
  output logic                  BID,
  output logic [1:0]            BRESP,
  output logic                  BVALID,
  input  logic                  BREADY,
  input  logic                  w_ready,
  output logic                  w_valid,
  output logic [ADDR_W-1:0]     w_addr,
  output logic [DATA_W-1:0]     w_data,
  output logic [DATA_W/8-1:0]   w_strb,
  output logic                  w_last
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned CNT_W  = 9;

  state_e            state_q, state_d;
  logic              awready_q, awready_d;
  logic              bvalid_q, bvalid_d;
  logic              bid_q, bid_d;
  logic [1:0]        bresp_q, bresp_d;
  aw_ctrl_t          ctrl_q, ctrl_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;

  logic              in_data_c;
  logic              beat_acc_c;
  logic              last_beat_c;
  logic              suppress_c;
  logic              wlast_bad_c;
  logic [ADDR_W-1:0] next_addr_c;

  axi_waddr_gen #(
    .ADDR_W (ADDR_W)
  ) u_waddr_gen (
    .addr        (addr_q),
    .size        (ctrl_q.size),
    .burst       (ctrl_q.burst),
    .next_addr_c (next_addr_c)
  );

  // Beat acceptance and core write-port decode
  always_comb begin
    in_data_c   = (state_q == ST_DATA);
    beat_acc_c  = in_data_c && WVALID && w_ready;
    last_beat_c = (cnt_q == {1'b0, ctrl_q.len});
    suppress_c  = ctrl_q.burst[1] || !size_ok(ctrl_q.size, STRB_W);
    wlast_bad_c = (WLAST != last_beat_c);
  end

  assign AWREADY = awready_q;
  assign WREADY  = in_data_c && w_ready;
  assign BVALID  = bvalid_q;
  assign BID     = bid_q;
  assign BRESP   = bresp_q;
  assign w_valid = beat_acc_c && !suppress_c;
  assign w_addr  = addr_q;
  assign w_data  = WDATA;
  assign w_strb  = WSTRB;
  assign w_last  = beat_acc_c && last_beat_c;

  // Next-state and registered-output computation
  always_comb begin
    state_d   = state_q;
    awready_d = awready_q;
    bvalid_d  = bvalid_q;
    bid_d     = bid_q;
    bresp_d   = bresp_q;
    ctrl_d    = ctrl_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (AWVALID && awready_q) begin
          ctrl_d.id    = AWID;
          ctrl_d.len   = AWLEN;
          ctrl_d.size  = AWSIZE;
          ctrl_d.burst = AWBURST;
          addr_d       = AWADDR;
          cnt_d        = '0;
          err_d        = 1'b0;
          awready_d    = 1'b0;
          state_d      = ST_DATA;
        end
      end
      ST_DATA: begin
        if (beat_acc_c) begin
          cnt_d  = cnt_q + CNT_W'(1);
          addr_d = next_addr_c;
          if (wlast_bad_c) begin
            err_d = 1'b1;
          end
          if (last_beat_c) begin
            state_d  = ST_RESP;
            bvalid_d = 1'b1;
            bid_d    = ctrl_q.id;
            bresp_d  = (err_q || wlast_bad_c || suppress_c) ? RESP_SLVERR : RESP_OKAY;
          end
        end
      end
      ST_RESP: begin
        if (bvalid_q && BREADY) begin
          bvalid_d  = 1'b0;
          err_d     = 1'b0;
          awready_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        awready_d = 1'b1;
        bvalid_d  = 1'b0;
      end
    endcase
  end

  // State and register update with synchronous reset
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q   <= ST_IDLE;
      awready_q <= 1'b1;
      bvalid_q  <= 1'b0;
      bid_q     <= 1'b0;
      bresp_q   <= RESP_OKAY;
      ctrl_q    <= '0;
      addr_q    <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      awready_q <= awready_d;
      bvalid_q  <= bvalid_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
      ctrl_q    <= ctrl_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_axi_write.sv
// Directed bench for axi_write: burst table plus stall, backpressure and reset corner cases.
module tb_axi_write;

  logic        ACLK;
  logic        ARESET;
  logic        AWID;
  logic [31:0] AWADDR;
  logic [7:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WLAST;
  logic        WVALID;
  logic        WREADY;
  logic        BID;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic        w_ready;
  logic        w_valid;
  logic [31:0] w_addr;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic        w_last;

  int errors = 0;
  int checks = 0;

  axi_write #(.ADDR_W(32), .DATA_W(32)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .w_ready(w_ready), .w_valid(w_valid), .w_addr(w_addr), .w_data(w_data),
    .w_strb(w_strb), .w_last(w_last)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        id;
    int          wlast_at;   // beat index driving WLAST=1, -1 for never
    int          stall_at;   // beat preceded by 3 w_ready-low cycles, -1 for none
    int          bwait;      // cycles BREADY held low in response phase
    int          abort_at;   // beat index replaced by a reset, -1 for none
    logic [31:0] step;       // expected address increment per beat
    logic        wv;         // expected core write strobe on accepted beats
    logic [1:0]  resp;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int k, input vec_t v);
    logic [31:0] ea;
    // address phase
    AWVALID = 1'b1; AWID = v.id; AWADDR = v.addr; AWLEN = v.len;
    AWSIZE = v.size; AWBURST = v.burst;
    #1 chk($sformatf("v%0d awready_idle", k), 32'(AWREADY), 32'd1);
    @(negedge ACLK);
    AWVALID = 1'b0;
    for (int i = 0; i <= int'(v.len); i++) begin
      ea = v.addr + 32'(i) * v.step;
      if (i == v.abort_at) begin
        WVALID = 1'b0; ARESET = 1'b1;
        @(negedge ACLK);
        ARESET = 1'b0; WVALID = 1'b1; w_ready = 1'b1;
        #1;
        chk($sformatf("v%0d rst awready", k), 32'(AWREADY), 32'd1);
        chk($sformatf("v%0d rst bvalid", k), 32'(BVALID), 32'd0);
        chk($sformatf("v%0d rst bid", k), 32'(BID), 32'd0);
        chk($sformatf("v%0d rst bresp", k), 32'(BRESP), 32'd0);
        chk($sformatf("v%0d rst wready", k), 32'(WREADY), 32'd0);
        chk($sformatf("v%0d rst w_valid", k), 32'(w_valid), 32'd0);
        WVALID = 1'b0;
        return;
      end
      if (i == v.stall_at) begin
        for (int s = 0; s < 3; s++) begin
          WVALID = 1'b1; w_ready = 1'b0; AWVALID = 1'b1; WLAST = 1'b0;
          #1;
          chk($sformatf("v%0d stall%0d wready", k, s), 32'(WREADY), 32'd0);
          chk($sformatf("v%0d stall%0d w_valid", k, s), 32'(w_valid), 32'd0);
          chk($sformatf("v%0d stall%0d awready", k, s), 32'(AWREADY), 32'd0);
          chk($sformatf("v%0d stall%0d w_addr", k, s), w_addr, ea);
          @(negedge ACLK);
        end
        AWVALID = 1'b0;
      end
      WVALID = 1'b1; w_ready = 1'b1;
      WDATA = 32'hA500_0000 | 32'(i);
      WSTRB = 4'(i) ^ 4'hA;
      WLAST = (i == v.wlast_at);
      #1;
      chk($sformatf("v%0d b%0d wready", k, i), 32'(WREADY), 32'd1);
      chk($sformatf("v%0d b%0d w_valid", k, i), 32'(w_valid), 32'(v.wv));
      chk($sformatf("v%0d b%0d w_last", k, i), 32'(w_last), 32'(i == int'(v.len)));
      if (v.wv) begin
        chk($sformatf("v%0d b%0d w_addr", k, i), w_addr, ea);
        chk($sformatf("v%0d b%0d w_data", k, i), w_data, 32'hA500_0000 | 32'(i));
        chk($sformatf("v%0d b%0d w_strb", k, i), 32'(w_strb), 32'(4'(i) ^ 4'hA));
      end
      @(negedge ACLK);
    end
    // response phase: hold BREADY low, poke AWVALID/WVALID which must be ignored
    WVALID = 1'b0; WLAST = 1'b0; BREADY = 1'b0;
    for (int c = 0; c < v.bwait; c++) begin
      AWVALID = 1'b1; WVALID = 1'b1;
      #1;
      chk($sformatf("v%0d hold%0d bvalid", k, c), 32'(BVALID), 32'd1);
      chk($sformatf("v%0d hold%0d bresp", k, c), 32'(BRESP), 32'(v.resp));
      chk($sformatf("v%0d hold%0d bid", k, c), 32'(BID), 32'(v.id));
      chk($sformatf("v%0d hold%0d awready", k, c), 32'(AWREADY), 32'd0);
      chk($sformatf("v%0d hold%0d wready", k, c), 32'(WREADY), 32'd0);
      chk($sformatf("v%0d hold%0d w_valid", k, c), 32'(w_valid), 32'd0);
      @(negedge ACLK);
    end
    AWVALID = 1'b0; WVALID = 1'b0; BREADY = 1'b1;
    #1;
    chk($sformatf("v%0d bvalid", k), 32'(BVALID), 32'd1);
    chk($sformatf("v%0d bresp", k), 32'(BRESP), 32'(v.resp));
    chk($sformatf("v%0d bid", k), 32'(BID), 32'(v.id));
    @(negedge ACLK);
    BREADY = 1'b0;
    #1;
    chk($sformatf("v%0d bvalid_clr", k), 32'(BVALID), 32'd0);
    chk($sformatf("v%0d awready_back", k), 32'(AWREADY), 32'd1);
  endtask

  initial begin
    //           addr          len    size  burst  id  wl   st  bw ab  step  wv  resp
    vecs[0]  = '{32'h0000_0100, 8'd3,   3'd2, 2'b01, 1'b1, 3,  -1, 0, -1, 32'd4, 1'b1, 2'b00};
    vecs[1]  = '{32'h0000_0040, 8'd1,   3'd2, 2'b00, 1'b0, 1,  -1, 0, -1, 32'd0, 1'b1, 2'b00};
    vecs[2]  = '{32'hFFFF_FFFC, 8'd1,   3'd2, 2'b01, 1'b1, 1,  -1, 0, -1, 32'd4, 1'b1, 2'b00};
    vecs[3]  = '{32'h0000_0200, 8'd2,   3'd2, 2'b01, 1'b0, 1,  -1, 5, -1, 32'd4, 1'b1, 2'b10};
    vecs[4]  = '{32'h0000_0500, 8'd3,   3'd2, 2'b01, 1'b1, 3,   2, 0, -1, 32'd4, 1'b1, 2'b00};
    vecs[5]  = '{32'h0000_0800, 8'd7,   3'd2, 2'b01, 1'b0, 7,  -1, 0,  2, 32'd4, 1'b1, 2'b00};
    vecs[6]  = '{32'h0000_0000, 8'd0,   3'd2, 2'b01, 1'b1, 0,  -1, 0, -1, 32'd4, 1'b1, 2'b00};
    vecs[7]  = '{32'h0000_0300, 8'd1,   3'd2, 2'b10, 1'b0, 1,  -1, 0, -1, 32'd0, 1'b0, 2'b10};
    vecs[8]  = '{32'h0000_0300, 8'd1,   3'd3, 2'b01, 1'b1, 1,  -1, 0, -1, 32'd8, 1'b0, 2'b10};
    vecs[9]  = '{32'h0000_0010, 8'd2,   3'd1, 2'b01, 1'b0, -1, -1, 0, -1, 32'd2, 1'b1, 2'b10};
    vecs[10] = '{32'h0000_1000, 8'd255, 3'd2, 2'b01, 1'b1, 255, -1, 2, -1, 32'd4, 1'b1, 2'b00};
    vecs[11] = '{32'h0000_0020, 8'd0,   3'd2, 2'b11, 1'b0, 0,  -1, 0, -1, 32'd0, 1'b0, 2'b10};

    ARESET = 1'b1; AWID = 1'b0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0;
    AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0;
    BREADY = 1'b0; w_ready = 1'b0;
    @(negedge ACLK);
    @(negedge ACLK);
    ARESET = 1'b0;
    WVALID = 1'b1; w_ready = 1'b1;
    #1;
    chk("reset awready", 32'(AWREADY), 32'd1);
    chk("reset wready", 32'(WREADY), 32'd0);
    chk("reset w_valid", 32'(w_valid), 32'd0);
    chk("reset bvalid", 32'(BVALID), 32'd0);
    chk("reset bid", 32'(BID), 32'd0);
    chk("reset bresp", 32'(BRESP), 32'd0);
    @(negedge ACLK);
    chk("idle wready", 32'(WREADY), 32'd0);
    WVALID = 1'b0;

    for (int k = 0; k < NV; k++) begin
      run_vec(k, vecs[k]);
      @(negedge ACLK);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_write.md
AXI_WRITE -- requirements
Module: axi_write

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width; WSTRB width is DATA_W/8.
REQ-003 SHALL have ports:
- ACLK  in  1  clock; all logic on rising edge.
- ARESET  in  1  synchronous, active-high reset.
- AWID  in  1  write ID.
- AWADDR  in  ADDR_W  burst start address.
- AWLEN  in  8  beats minus 1.
- AWSIZE  in  3  bytes per beat = 2^AWSIZE.
- AWBURST  in  2  burst type.
- AWVALID  in  1  / AWREADY  out  1  address handshake.
- WDATA  in  DATA_W  write data.
- WSTRB  in  DATA_W/8  byte enables.
- WLAST  in  1  last beat marker.
- WVALID  in  1  / WREADY  out  1  data handshake.
- BID  out  1  response ID.
- BRESP  out  2  write response.
- BVALID  out  1  / BREADY  in  1  response handshake.
- w_ready  in  1  core can accept a beat this cycle.
- w_valid  out  1  core write strobe.
- w_addr  out  ADDR_W  beat address.
- w_data  out  DATA_W  beat data.
- w_strb  out  DATA_W/8  beat byte enables.
- w_last  out  1  final beat of burst.

Function
REQ-004 SHALL implement FSM IDLE, DATA, RESP; exactly one burst outstanding.
REQ-005 IDLE: AWREADY=1, WREADY=0, BVALID=0; on AWVALID&AWREADY latch AWID, AWADDR, AWLEN, AWSIZE, AWBURST; clear beat counter; go to DATA next cycle.
REQ-006 DATA: AWREADY=0; WREADY = w_ready (combinational).
REQ-007 A beat is accepted when WVALID&WREADY; w_valid = WVALID&WREADY in the same cycle (zero latency); w_data=WDATA, w_strb=WSTRB, w_addr = current beat address register.
REQ-008 w_last SHALL be 1 on the accepted beat where beat counter == latched AWLEN.
REQ-009 Beat address: FIXED (2'b00) holds start address; INCR (2'b01) adds 2^AWSIZE per accepted beat, ADDR_W-bit wrap-around modulo 2^ADDR_W.
REQ-010 WRAP (2'b10) and reserved (2'b11): beats accepted with w_valid forced 0 (no core write); response SLVERR.
REQ-011 AWSIZE greater than log2(DATA_W/8) SHALL give SLVERR; beats accepted without core writes.
REQ-012 WLAST mismatch (WLAST=1 before final beat, or WLAST=0 on final beat) SHALL set a sticky error flag -> SLVERR; beat count by AWLEN governs burst end.
REQ-013 After final beat accepted: go to RESP next cycle; BVALID=1, BID=latched AWID, BRESP = 2'b00 OKAY or 2'b10 SLVERR.
REQ-014 RESP: hold BVALID, BID, BRESP stable until BREADY; on BVALID&BREADY clear BVALID, error flag; go to IDLE, AWREADY=1 next cycle.
REQ-015 AWVALID during DATA/RESP SHALL be ignored (held off by AWREADY=0).
REQ-016 WVALID in IDLE/RESP SHALL not be accepted (WREADY=0).
REQ-017 AWLEN=0 SHALL be a single-beat burst with w_last=1 on that beat.
REQ-018 AWLEN=255: 256 beats; 9-bit beat counter, no overflow.

Reset
REQ-019 ARESET=1 at any rising edge SHALL force IDLE, AWREADY=1, WREADY=0, BVALID=0, BID=0, BRESP=0, w_valid=0, counter/address/error cleared; in-flight burst discarded, no response issued.

Structure
REQ-020 Shared package axi_pkg SHALL hold BURST_FIXED/INCR/WRAP, RESP_OKAY=2'b00, RESP_SLVERR=2'b10, FSM state encoding.
REQ-021 One sub-module axi_waddr_gen SHALL compute next beat address from address, size, burst type.

Verification
REQ-022 AWADDR=0x100, AWLEN=3, AWSIZE=2, INCR, WLAST on 4th -> w_addr 0x100,0x104,0x108,0x10C; w_last on 4th; BRESP=00, BID=AWID.
REQ-023 FIXED, AWLEN=1, AWADDR=0x40 -> w_addr 0x40 twice; BRESP=00.
REQ-024 w_ready low 3 cycles mid-burst -> WREADY low, no w_valid, no lost/duplicated beats.
REQ-025 AWLEN=2, WLAST on 2nd beat -> 3 beats still accepted, BRESP=10; BREADY held 0 5 cycles -> BVALID/BRESP stable.
REQ-026 ARESET=1 after beat 2 of AWLEN=7 -> IDLE, AWREADY=1, BVALID=0; next burst AWADDR=0x0, AWLEN=0 completes OKAY.
REQ-027 AWADDR=0xFFFFFFFC, AWLEN=1, INCR, AWSIZE=2 -> w_addr 0xFFFFFFFC then 0x00000000.
